// File: rtl/frame_tx_arbiter_if.sv
// Frame TX arbiter bus: per-source byte streams in, merged MAC TX stream out.
// slave = arbiter side, master = builders/MAC side.
interface frame_tx_arbiter_if #(
    parameter int NUM_SRC = 3
);
    logic [8*NUM_SRC-1:0] src_tdata_in;
    logic [NUM_SRC-1:0]   src_tvalid_in;
    logic [NUM_SRC-1:0]   src_tready_out;
    logic [NUM_SRC-1:0]   src_tlast_in;
    logic [7:0]           net_tdata_out;
    logic                 net_tvalid_out;
    logic                 net_tready_in;
    logic                 net_tlast_out;

    modport slave (
        input  src_tdata_in, src_tvalid_in, src_tlast_in, net_tready_in,
        output src_tready_out, net_tdata_out, net_tvalid_out, net_tlast_out
    );

    modport master (
        output src_tdata_in, src_tvalid_in, src_tlast_in, net_tready_in,
        input  src_tready_out, net_tdata_out, net_tvalid_out, net_tlast_out
    );
endinterface

// File: rtl/frame_tx_arbiter.sv
// Round-robin whole-frame arbiter for the net TX byte stream, with length truncation.
// Define FRAME_TX_IFG_EN to insert IFG_CYCLES idle cycles after every frame.
module frame_tx_arbiter #(
    parameter int NUM_SRC       = 3,
    parameter int MAX_FRAME_LEN = 1514,
    parameter int IFG_CYCLES    = 12
) (
    input  logic               logic_clk,
    input  logic               logic_rst_n,
    frame_tx_arbiter_if.slave  bus,
    output logic [NUM_SRC-1:0] grant_out,
    output logic               busy_out,
    output logic               len_err_out
);
    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CW = 11;
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_FRAME_LEN - 1);
`ifdef FRAME_TX_IFG_EN
    localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_DROP
`ifdef FRAME_TX_IFG_EN
        , S_GAP
`endif
    } state_t;

`ifdef FRAME_TX_IFG_EN
    localparam state_t END_ST = S_GAP;
`else
    localparam state_t END_ST = S_IDLE;
`endif

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
`ifdef FRAME_TX_IFG_EN
    logic [GW-1:0]      gap_q, gap_d;
`endif

    logic [NUM_SRC-1:0][7:0] lane;
    logic [IW-1:0]           cand, pick, rr_pick;
    logic                    found;
    logic                    g_valid, g_last, beat, at_max;

    logic [NUM_SRC-1:0] src_tready;
    logic [7:0]         net_tdata;
    logic               net_tvalid, net_tlast, len_err;

    assign lane = bus.src_tdata_in;

    // First requester at or after rr_q, wrapping around
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = IW'((int'(rr_q) + k) % NUM_SRC);
            if (!found && bus.src_tvalid_in[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        rr_pick = IW'((int'(pick) + 1) % NUM_SRC);
    end

    assign g_valid = bus.src_tvalid_in[gidx_q];
    assign g_last  = bus.src_tlast_in[gidx_q];
    assign at_max  = (cnt_q == LAST_CNT);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
`ifdef FRAME_TX_IFG_EN
        gap_d      = gap_q;
`endif
        src_tready = '0;
        net_tdata  = '0;
        net_tvalid = 1'b0;
        net_tlast  = 1'b0;
        len_err    = 1'b0;
        beat       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = NUM_SRC'(1) << pick;
                    gidx_d  = pick;
                    rr_d    = rr_pick;
                    state_d = S_XFER;
                end
            end

            S_XFER: begin
                net_tdata          = lane[gidx_q];
                net_tvalid         = g_valid;
                net_tlast          = g_last | at_max;
                src_tready[gidx_q] = bus.net_tready_in;
                beat               = g_valid & bus.net_tready_in;
                if (beat) begin
                    if (g_last) begin
                        // A real last on the limit beat is a clean end, not a truncation
                        grant_d = '0;
                        gidx_d  = '0;
                        cnt_d   = '0;
                        state_d = END_ST;
`ifdef FRAME_TX_IFG_EN
                        gap_d   = '0;
`endif
                    end else if (at_max) begin
                        len_err = 1'b1;
                        cnt_d   = '0;
                        state_d = S_DROP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_DROP: begin
                // Sink the tail of the truncated frame; nothing reaches the MAC
                src_tready[gidx_q] = 1'b1;
                if (g_valid && g_last) begin
                    grant_d = '0;
                    gidx_d  = '0;
                    state_d = END_ST;
`ifdef FRAME_TX_IFG_EN
                    gap_d   = '0;
`endif
                end
            end

`ifdef FRAME_TX_IFG_EN
            S_GAP: begin
                if (gap_q == GW'(IFG_CYCLES - 1)) state_d = S_IDLE;
                else                              gap_d   = gap_q + GW'(1);
            end
`endif

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge logic_clk or negedge logic_rst_n) begin
        if (!logic_rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
`ifdef FRAME_TX_IFG_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
`ifdef FRAME_TX_IFG_EN
            gap_q   <= gap_d;
`endif
        end
    end

    assign bus.src_tready_out = src_tready;
    assign bus.net_tdata_out  = net_tdata;
    assign bus.net_tvalid_out = net_tvalid;
    assign bus.net_tlast_out  = net_tlast;
    assign grant_out          = grant_q;
    assign busy_out           = (state_q != S_IDLE);
    assign len_err_out        = len_err;
endmodule

// File: tb/tb_frame_tx_arbiter.sv
// Directed bench for frame_tx_arbiter: source byte pattern is 8'(src*80 + byte_index).
module tb_frame_tx_arbiter;
    localparam int NS   = 3;
    localparam int MAXL = 1514;
    localparam int IFG  = 12;
`ifdef FRAME_TX_IFG_EN
    localparam int EXP_GAP = IFG + 2;
`else
    localparam int EXP_GAP = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    frame_tx_arbiter_if #(.NUM_SRC(NS)) bus();
    logic [NS-1:0] grant;
    logic          busy, len_err;

    frame_tx_arbiter #(.NUM_SRC(NS), .MAX_FRAME_LEN(MAXL), .IFG_CYCLES(IFG)) dut (
        .logic_clk   (clk),
        .logic_rst_n (rst_n),
        .bus         (bus),
        .grant_out   (grant),
        .busy_out    (busy),
        .len_err_out (len_err)
    );

    // Source model: each builder streams a loaded frame length
    int            rem  [NS];
    int            sent [NS];
    int            ld_len;
    logic [NS-1:0] ld_stb;

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NS; i++) begin
            if (!rst_n) begin
                rem[i]  <= 0;
                sent[i] <= 0;
            end else if (ld_stb[i]) begin
                rem[i]  <= ld_len;
                sent[i] <= 0;
            end else if (bus.src_tvalid_in[i] && bus.src_tready_out[i]) begin
                rem[i]  <= rem[i] - 1;
                sent[i] <= sent[i] + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            bus.src_tvalid_in[i]        = (rem[i] > 0);
            bus.src_tlast_in[i]         = (rem[i] == 1);
            bus.src_tdata_in[8*i +: 8]  = 8'(i*80 + sent[i]);
        end
    end

    // Monitor, sampled mid-cycle
    int cyc = 0, cur_len = 0, cur_derr = 0, cur_first = 0;
    int lerr_cnt = 0, sunk = 0, mir_err = 0;
    int fr_src[$], fr_len[$], fr_derr[$], fr_first[$], fr_lastc[$];

    always @(negedge clk) begin
        int s;
        cyc++;
        if (!rst_n) begin
            cur_len  = 0;
            cur_derr = 0;
        end else begin
            s = (grant == 3'b010) ? 1 : (grant == 3'b100) ? 2 : 0;
            if (len_err) lerr_cnt++;
            if (grant != 0 && !bus.net_tvalid_out && |(bus.src_tready_out & bus.src_tvalid_in)) sunk++;
            if (grant == 3'b010 && bus.src_tready_out != {1'b0, bus.net_tready_in, 1'b0}) mir_err++;
            if (bus.net_tvalid_out && bus.net_tready_in) begin
                if (cur_len == 0) cur_first = cyc;
                if (bus.net_tdata_out != 8'(s*80 + cur_len)) cur_derr++;
                cur_len++;
                if (bus.net_tlast_out) begin
                    fr_src.push_back(s);
                    fr_len.push_back(cur_len);
                    fr_derr.push_back(cur_derr);
                    fr_first.push_back(cur_first);
                    fr_lastc.push_back(cyc);
                    cur_len  = 0;
                    cur_derr = 0;
                end
            end
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int frv(input int sel, input int i);
        if (i >= fr_src.size()) return -1;
        case (sel)
            0:       return fr_src[i];
            1:       return fr_len[i];
            2:       return fr_derr[i];
            3:       return fr_first[i];
            default: return fr_lastc[i];
        endcase
    endfunction

    task automatic load(input logic [NS-1:0] m, input int len);
        @(posedge clk); #1;
        ld_len = len;
        ld_stb = m;
        @(posedge clk); #1;
        ld_stb = '0;
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        int b = 0;
        while (fr_src.size() < n && b < budget) begin
            @(posedge clk); #1;
            b++;
        end
        chk(tag, fr_src.size(), n);
    endtask

    task automatic wait_idle(input string tag);
        int b = 0;
        while ((busy || rem[0] != 0 || rem[1] != 0 || rem[2] != 0) && b < 300) begin
            @(posedge clk); #1;
            b++;
        end
        chk(tag, int'(busy), 0);
    endtask

    int base;

    initial begin
        bus.net_tready_in = 1'b1;
        ld_stb = '0;
        ld_len = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant",  int'(grant), 0);
        chk("rst_busy",   int'(busy), 0);
        chk("rst_nvalid", int'(bus.net_tvalid_out), 0);
        chk("rst_sready", int'(bus.src_tready_out), 0);
        chk("rst_lenerr", int'(len_err), 0);
        rst_n = 1'b1;

        // All three request together from rr_ptr=0
        base = fr_src.size();
        load(3'b111, 60);
        wait_frames("rr3_frames", base + 3, 400);
        chk("rr3_src0", frv(0, base), 0);
        chk("rr3_src1", frv(0, base + 1), 1);
        chk("rr3_src2", frv(0, base + 2), 2);
        chk("rr3_len0", frv(1, base), 60);
        chk("rr3_len1", frv(1, base + 1), 60);
        chk("rr3_len2", frv(1, base + 2), 60);
        chk("rr3_derr", frv(2, base) + frv(2, base + 1) + frv(2, base + 2), 0);
        wait_idle("rr3_idle");

        // After UDP the pointer wraps back to ARP
        base = fr_src.size();
        load(3'b011, 5);
        wait_frames("wrap_frames", base + 2, 100);
        chk("wrap_first", frv(0, base), 0);
        chk("wrap_second", frv(0, base + 1), 1);
        wait_idle("wrap_idle");

        // ARP alone, 42 bytes
        base = fr_src.size();
        load(3'b001, 42);
        chk("arp_grant_pre", int'(grant), 0);
        @(posedge clk); #1;
        chk("arp_grant", int'(grant), 1);
        wait_frames("arp_frames", base + 1, 200);
        chk("arp_len", frv(1, base), 42);
        chk("arp_derr", frv(2, base), 0);
        chk("arp_lenerr", lerr_cnt, 0);
        wait_idle("arp_idle");

        // ICMP with net_tready toggling every cycle
        base = fr_src.size();
        load(3'b010, 10);
        for (int b = 0; b < 200 && fr_src.size() < base + 1; b++) begin
            @(posedge clk); #1;
            bus.net_tready_in = ~bus.net_tready_in;
        end
        bus.net_tready_in = 1'b1;
        chk("icmp_frames", fr_src.size(), base + 1);
        chk("icmp_src", frv(0, base), 1);
        chk("icmp_len", frv(1, base), 10);
        chk("icmp_derr", frv(2, base), 0);
        chk("icmp_mirror", mir_err, 0);
        wait_idle("icmp_idle");

        // Oversize UDP frame is truncated at MAXL and the rest sunk
        base = fr_src.size();
        load(3'b100, 1600);
        wait_frames("trunc_frames", base + 1, 2000);
        chk("trunc_src", frv(0, base), 2);
        chk("trunc_len", frv(1, base), MAXL);
        chk("trunc_derr", frv(2, base), 0);
        wait_idle("trunc_idle");
        chk("trunc_lenerr", lerr_cnt, 1);
        chk("trunc_sunk", sunk, 1600 - MAXL);

        // Exactly MAXL bytes: clean end, no error
        base = fr_src.size();
        load(3'b100, MAXL);
        wait_frames("exact_frames", base + 1, 2000);
        chk("exact_len", frv(1, base), MAXL);
        wait_idle("exact_idle");
        chk("exact_lenerr", lerr_cnt, 1);
        chk("exact_sunk", sunk, 1600 - MAXL);

        // ARP then UDP back to back: spacing from ARP last to UDP first
        base = fr_src.size();
        load(3'b101, 8);
        wait_frames("b2b_frames", base + 2, 200);
        chk("b2b_first", frv(0, base), 0);
        chk("b2b_second", frv(0, base + 1), 2);
        chk("b2b_gap", frv(3, base + 1) - frv(4, base), EXP_GAP);
        wait_idle("b2b_idle");

        // Reset mid-frame at byte 20 of 60
        base = fr_src.size();
        load(3'b001, 60);
        for (int b = 0; b < 100 && cur_len < 20; b++) begin
            @(posedge clk); #1;
        end
        chk("rst_at_byte", cur_len, 20);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant",  int'(grant), 0);
        chk("mid_rst_busy",   int'(busy), 0);
        chk("mid_rst_nvalid", int'(bus.net_tvalid_out), 0);
        chk("mid_rst_nlast",  int'(bus.net_tlast_out), 0);
        chk("mid_rst_ndata",  int'(bus.net_tdata_out), 0);
        chk("mid_rst_sready", int'(bus.src_tready_out), 0);
        chk("mid_rst_nframe", fr_src.size(), base);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = fr_src.size();
        load(3'b101, 4);
        wait_frames("post_rst_frames", base + 2, 100);
        chk("post_rst_first", frv(0, base), 0);
        chk("post_rst_second", frv(0, base + 1), 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
